// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the two-requester DataMemory arbiter.
package data_mem_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int REQ_LSU = 0;
    localparam int REQ_DBG = 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie, the requester that did not win last time wins.
module rr_arbiter2
    import data_mem_arb_pkg::*;
(
    input  logic               en,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (en) begin
            // last_grant == 1 means the debug port won last, so the LSU has priority
            if (req_valid[REQ_LSU] && (!req_valid[REQ_DBG] || last_grant)) begin
                grant[REQ_LSU] = 1'b1;
            end else if (req_valid[REQ_DBG]) begin
                grant[REQ_DBG] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates LSU and debug/DMA requests onto the single-port DataMemory,
// one access per IDLE/RESP -> ISSUE -> RESP slot, with a one-cycle response strobe.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_W-1:0]               rsp_rdata,
    output logic [ADDR_W-1:0]               mem_address,
    output logic [DATA_W-1:0]               mem_write_data,
    output logic                            mem_read,
    output logic                            mem_write,
    input  logic [DATA_W-1:0]               mem_read_data
);

    arb_state_t          state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                owner_q, owner_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [NUM_REQ-1:0]  grant;
    logic                accept_en;
    logic                accept;
    logic                sel;

    // Gating with rst_n keeps req_ready low for the whole time reset is held.
    assign accept_en = rst_n && (state_q != ISSUE);

    rr_arbiter2 u_rr_arbiter2 (
        .en         (accept_en),
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign accept    = |grant;
    assign sel       = grant[REQ_DBG];
    assign req_ready = grant;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        owner_d      = owner_q;
        rdata_d      = rdata_q;

        if (accept) begin
            addr_d       = req_addr[sel];
            wdata_d      = req_wdata[sel];
            we_d         = req_we[sel];
            owner_d      = sel;
            last_grant_d = sel;
        end

        case (state_q)
            IDLE:  if (accept) state_d = ISSUE;
            ISSUE: begin
                state_d = RESP;
                if (!we_q) rdata_d = mem_read_data;
            end
            RESP:  state_d = accept ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            owner_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            owner_q      <= owner_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) rsp_valid[owner_q] = 1'b1;
    end

    assign rsp_rdata      = rdata_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_read       = (state_q == ISSUE) && !we_q;
    assign mem_write      = (state_q == ISSUE) && we_q;

endmodule
